// File: rtl/mul_issue_pkg.sv
// Shared definitions for the multiplier issue block (package mul_pkg).
// Holds the operand, tag and product widths, the FSM state encoding and the
// queued request record. The magnitude helper exists only when the
// MUL_ISSUE_SIGNED_EN macro is defined.
package mul_pkg;

    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [TAG_W-1:0] tag;
    } req_t;

`ifdef MUL_ISSUE_SIGNED_EN
    // Two's-complement magnitude. 0x80000000 maps to itself, which the
    // unsigned multiplier reads as 2^31.
    function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? (~v + 1'b1) : v;
    endfunction
`endif

endpackage

// File: rtl/mul_issue_if.sv
// Bus bundle for mul_issue: operand handshake (in_*), result handshake
// (out_*), the multiplier drive/return signals (mul_*) and busy.
// Modport slave is the mul_issue side; modport master is the side that
// supplies operands, consumes results and models the multiplier.
interface mul_issue_if;
    import mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_product;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic              mul_start;
    logic [OP_W-1:0]   mul_multiplicand;
    logic [OP_W-1:0]   mul_multiplier;
    logic [PROD_W-1:0] mul_product;
    logic              mul_finish;

    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready, mul_product, mul_finish,
        output in_ready, out_valid, out_product, out_tag, out_err,
               mul_start, mul_multiplicand, mul_multiplier, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready, mul_product, mul_finish,
        input  in_ready, out_valid, out_product, out_tag, out_err,
               mul_start, mul_multiplicand, mul_multiplier, busy
    );

endinterface

// File: rtl/mul_issue_fifo.sv
// Synchronous show-ahead operand queue for mul_issue.
// Ports: clk, rst (async, active-low), push/wdata, pop/rdata (head entry,
// valid while !empty), full, empty. DEPTH must be a power of two.
module mul_issue_fifo
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t wdata,
    input  logic pop,
    output req_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mul_issue.sv
// Issue stage in front of a sequential multiplier: queues operand requests,
// issues one multiply at a time, waits for mul_finish with a timeout, and
// holds the result until it is accepted downstream.
// Ports: clk, rst (async, active-low), bus (mul_issue_if.slave) carrying
// in_* operand handshake, out_* result handshake, mul_* multiplier drive and
// return, busy.
// Macro MUL_ISSUE_SIGNED_EN: treat operands as two's-complement, issue
// magnitudes and negate the captured product when the signs differ.
module mul_issue
    import mul_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 40
) (
    input  logic           clk,
    input  logic           rst,
    mul_issue_if.slave     bus
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              empty;
    logic              pop;
    req_t              head;
    req_t              in_req;
    logic [OP_W-1:0]   issue_a;
    logic [OP_W-1:0]   issue_b;
    logic [PROD_W-1:0] result;

    logic              mul_start;
    logic [OP_W-1:0]   mcand;
    logic [OP_W-1:0]   mplier;
    logic              out_valid;
    logic [PROD_W-1:0] out_product;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    assign in_req = '{a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
    assign pop    = (state == IDLE) && !empty;

    mul_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid && bus.in_ready),
        .wdata (in_req),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef MUL_ISSUE_SIGNED_EN
    logic neg;
    assign issue_a = magnitude(head.a);
    assign issue_b = magnitude(head.b);
    assign result  = neg ? -bus.mul_product : bus.mul_product;
`else
    assign issue_a = head.a;
    assign issue_b = head.b;
    assign result  = bus.mul_product;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mul_start   <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
            out_err     <= 1'b0;
`ifdef MUL_ISSUE_SIGNED_EN
            neg         <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    // out_valid is low here, so out_tag may take the new tag now.
                    if (!empty) begin
                        mcand     <= issue_a;
                        mplier    <= issue_b;
                        out_tag   <= head.tag;
`ifdef MUL_ISSUE_SIGNED_EN
                        neg       <= head.a[OP_W-1] ^ head.b[OP_W-1];
`endif
                        mul_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= ARM;
                end
                ARM: begin
                    // finish may still be stale from the previous multiply
                    cnt   <= cnt + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_finish) begin
                        out_product <= result;
                        out_err     <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (cnt == CW'(TIMEOUT_CYC)) begin
                        out_product <= '0;
                        out_err     <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is held low while reset is asserted.
    assign bus.in_ready         = rst && !full;
    assign bus.busy             = (state != IDLE) || !empty;
    assign bus.mul_start        = mul_start;
    assign bus.mul_multiplicand = mcand;
    assign bus.mul_multiplier   = mplier;
    assign bus.out_valid        = out_valid;
    assign bus.out_product      = out_product;
    assign bus.out_tag          = out_tag;
    assign bus.out_err          = out_err;

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): operand queue entries.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 40: maximum cycles to wait for mul_finish before abort.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1: operand handshake.
REQ-006 SHALL have ports in_a, in_b  in  32 (multiplicand, multiplier) and in_tag  in  4 (request id).
REQ-007 SHALL have ports out_valid out 1 / out_ready in 1: result handshake.
REQ-008 SHALL have ports out_product  out  64, out_tag  out  4, out_err  out  1 (timeout flag for this result).
REQ-009 SHALL have ports mul_start out 1, mul_multiplicand out 32, mul_multiplier out 32: drive to the sequential multiplier.
REQ-010 SHALL have ports mul_product in 64, mul_finish in 1: returned from the multiplier.
REQ-011 SHALL have port busy  out  1: FSM not in IDLE or queue not empty.

Function
REQ-012 SHALL accept an operand triple when in_valid && in_ready; in_ready = queue not full.
REQ-013 SHALL hold the queue in FIFO order; simultaneous push and pop with queue full SHALL NOT be accepted (in_ready low when full, no bypass).
REQ-014 SHALL implement FSM states IDLE, START, ARM, WAIT, HOLD.
REQ-015 IDLE -> START when queue non-empty and output register empty; pop head into operand/tag registers.
REQ-016 START: mul_start = 1 for exactly one cycle, operands stable on mul_multiplicand/mul_multiplier; -> ARM.
REQ-017 ARM: one cycle, mul_finish ignored (multiplier clears finish after start); -> WAIT.
REQ-018 WAIT: on mul_finish = 1 capture mul_product into out_product, out_err = 0, -> HOLD.
REQ-019 WAIT: cycle counter reaching TIMEOUT_CYC without finish SHALL set out_product = 0, out_err = 1, -> HOLD.
REQ-020 HOLD: out_valid = 1; out_product/out_tag/out_err stable until out_ready; on handshake -> IDLE.
REQ-021 Minimum issue-to-result latency SHALL be 3 cycles plus multiplier latency; one multiply outstanding at a time.
REQ-022 mul_multiplicand/mul_multiplier SHALL hold last issued operands outside START (no glitching to queue head).
REQ-023 Timeout counter SHALL reset on every entry to ARM.

Reset
REQ-024 On rst low: FSM IDLE, queue empty, in_ready 0 during reset then 1, out_valid 0, out_product 0, out_tag 0, out_err 0, mul_start 0, mul_multiplicand/mul_multiplier 0, busy 0.
REQ-025 Reset mid-operation SHALL discard queue and in-flight request; no result emitted for it.

Configuration
REQ-026 Macro MUL_ISSUE_SIGNED_EN defined: operands two's-complement; issue magnitudes |a|, |b| (0x80000000 passes unchanged as magnitude 2^31); negate captured product when sign(a) xor sign(b); -1 x 3 -> 0xFFFFFFFFFFFFFFFD.
REQ-027 Macro undefined: operands unsigned, passed through and product captured unmodified; no sign logic synthesised.

Structure
REQ-028 Shared package mul_pkg SHALL hold FSM state encoding, tag width (4), operand width (32), product width (64).
REQ-029 Operand queue SHALL be sub-module mul_issue_fifo (sync FIFO, DEPTH parameter, full/empty flags); FSM and sign logic in top.

Verification
REQ-030 Single request a=7, b=6, tag=3 with model multiplier -> one out_valid, out_product=42, out_tag=3, out_err=0; mul_start high exactly 1 cycle.
REQ-031 Push 5 requests back-to-back, depth 4 -> in_ready low after 4th until first pop; results in order, tags 0..4.
REQ-032 out_ready held low 20 cycles during HOLD -> out_product/tag stable, no new mul_start issued.
REQ-033 Multiplier model never asserts finish -> after TIMEOUT_CYC cycles out_err=1, out_product=0; next queued request proceeds normally.
REQ-034 Assert rst during WAIT with 2 queued -> all outputs to reset values, no results emitted after release.
REQ-035 With MUL_ISSUE_SIGNED_EN: a=0xFFFFFFFF, b=3 -> 0xFFFFFFFFFFFFFFFD; a=0x80000000, b=0x80000000 -> 0x4000000000000000.
